// File: rtl/bldc_commutation_ctrl.sv
// bldc_commutation_ctrl: hall-sensed six-step BLDC commutation.
// Hall path: 2-flop sync -> debounce -> accepted hall state.
// FSM (IDLE/DEAD/RUN/FAULT) inserts dead time on every commutation.
// It also PWMs the high side and latches hall faults.
// Optional build macro STALL_DETECT_EN adds a stall timeout (fault code 11).
module bldc_commutation_ctrl #(
  parameter int PWM_W        = 9,
  parameter int DEBOUNCE     = 4,
  parameter int DEAD_CYCLES  = 8,
  parameter int STALL_CYCLES = 1 << 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       hall,
  input  logic             enable,
  input  logic             dir,
  input  logic [PWM_W-1:0] duty,
  output logic [2:0]       phase_hi,
  output logic [2:0]       phase_lo,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [2:0]       hall_state,
  output logic [15:0]      edge_count
);

  localparam int DB_W = $clog2(DEBOUNCE + 1) + 1;
  localparam int DC_W = $clog2(DEAD_CYCLES + 1) + 1;

  typedef enum logic [1:0] {IDLE, DEAD, RUN, FLT} state_t;

  function automatic logic hall_ok(input logic [2:0] h);
    return (h != 3'b000) && (h != 3'b111);
  endfunction

  // successor of h in forward rotation
  function automatic logic [2:0] fwd_next(input logic [2:0] h);
    case (h)
      3'b101:  return 3'b100;
      3'b100:  return 3'b110;
      3'b110:  return 3'b010;
      3'b010:  return 3'b011;
      3'b011:  return 3'b001;
      3'b001:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic adjacent(input logic [2:0] a, input logic [2:0] b);
    return hall_ok(a) && hall_ok(b) && ((fwd_next(a) == b) || (fwd_next(b) == a));
  endfunction

  // forward drive table, {hi, lo}, phases ordered {A,B,C}
  function automatic logic [5:0] drive_fwd(input logic [2:0] h);
    case (h)
      3'b101:  return {3'b100, 3'b010};
      3'b100:  return {3'b100, 3'b001};
      3'b110:  return {3'b010, 3'b001};
      3'b010:  return {3'b010, 3'b100};
      3'b011:  return {3'b001, 3'b100};
      3'b001:  return {3'b001, 3'b010};
      default: return 6'b000000;
    endcase
  endfunction

  state_t state, next_state;

  logic [1:0][2:0]  hall_sync;
  logic [2:0]       hall_s, hall_last, hall_next;
  logic [DB_W-1:0]  stable_cnt, run_len;
  logic             acc, adj_edge, bad_inv, bad_jump, stall_hit;
  logic [DC_W-1:0]  dead_cnt;
  logic             dead_load, run_load, fault_set;
  logic [1:0]       code_n;
  logic [2:0]       drive_hi, drive_lo;
  logic             run_dir;
  logic [PWM_W-1:0] pwm_cnt;
  logic [5:0]       tbl;

  assign hall_s = hall_sync[1];

  // two-flop synchroniser for the asynchronous hall pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hall_sync <= '0;
    else        hall_sync <= {hall_sync[0], hall};
  end

  // run length of the current synced value including this cycle, saturated
  always_comb begin
    run_len = DB_W'(1);
    if (hall_s == hall_last)
      run_len = (stable_cnt >= DB_W'(DEBOUNCE)) ? DB_W'(DEBOUNCE) : stable_cnt + 1'b1;
  end

  assign acc       = (run_len >= DB_W'(DEBOUNCE)) && (hall_s != hall_state);
  assign hall_next = acc ? hall_s : hall_state;
  assign adj_edge  = acc && adjacent(hall_state, hall_s);
  assign bad_inv   = acc && !hall_ok(hall_s);
  assign bad_jump  = acc && hall_ok(hall_s) && hall_ok(hall_state) && !adjacent(hall_state, hall_s);

  // debounce tracking and accepted hall state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_last  <= '0;
      stable_cnt <= '0;
      hall_state <= '0;
    end else begin
      hall_last  <= hall_s;
      stable_cnt <= run_len;
      hall_state <= hall_next;
    end
  end

`ifdef STALL_DETECT_EN
  localparam int SW = $clog2(STALL_CYCLES + 1) + 1;
  logic [SW-1:0] stall_cnt;
  logic          stall_act;

  assign stall_act = ((state == RUN) || (state == DEAD)) && (duty != '0);
  assign stall_hit = stall_act && !acc && (stall_cnt >= SW'(STALL_CYCLES - 1));

  // stall timer: runs while driving with nonzero duty, cleared by any accepted edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                stall_cnt <= '0;
    else if ((state == IDLE) || (state == FLT) || acc) stall_cnt <= '0;
    else if (stall_act)                        stall_cnt <= stall_cnt + 1'b1;
  end
`else
  // no stall timer in this build; the timeout parameter has no effect
  assign stall_hit = (STALL_CYCLES < 0);
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // next-state logic; fault causes ranked invalid > illegal jump > stall
  always_comb begin
    next_state = state;
    dead_load  = 1'b0;
    run_load   = 1'b0;
    fault_set  = 1'b0;
    code_n     = 2'b00;
    if (bad_inv)        code_n = 2'b01;
    else if (bad_jump)  code_n = 2'b10;
    else if (stall_hit) code_n = 2'b11;
    case (state)
      IDLE: begin
        if (enable) begin
          if (bad_inv || bad_jump) begin
            next_state = FLT;
            fault_set  = 1'b1;
          end else if (hall_ok(hall_next)) begin
            next_state = DEAD;
            dead_load  = 1'b1;
          end
        end
      end
      DEAD: begin
        if (!enable) next_state = IDLE;
        else if (bad_inv || bad_jump || stall_hit) begin
          next_state = FLT;
          fault_set  = 1'b1;
        end else if (dead_cnt == '0) begin
          next_state = RUN;
          run_load   = 1'b1;
        end
      end
      RUN: begin
        if (!enable) next_state = IDLE;
        else if (bad_inv || bad_jump || stall_hit) begin
          next_state = FLT;
          fault_set  = 1'b1;
        end else if (adj_edge || (dir != run_dir)) begin
          next_state = DEAD;
          dead_load  = 1'b1;
        end
      end
      FLT: begin
        if (!enable) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // dead-time counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  dead_cnt <= '0;
    else if (dead_load)                          dead_cnt <= DC_W'(DEAD_CYCLES - 1);
    else if ((state == DEAD) && (dead_cnt != '0)) dead_cnt <= dead_cnt - 1'b1;
  end

  // drive pattern latched on entry to RUN so a dir change cannot glitch the gates
  assign tbl = drive_fwd(hall_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drive_hi <= '0;
      drive_lo <= '0;
      run_dir  <= 1'b0;
    end else if (run_load) begin
      drive_hi <= dir ? tbl[2:0] : tbl[5:3];
      drive_lo <= dir ? tbl[5:3] : tbl[2:0];
      run_dir  <= dir;
    end
  end

  // fault latch: first cause holds until enable drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else if (fault_set) begin
      fault      <= 1'b1;
      fault_code <= code_n;
    end else if ((state == FLT) && (next_state == IDLE)) begin
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end
  end

  // accepted adjacent transitions, counted unless faulted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       edge_count <= '0;
    else if (adj_edge && (state != FLT)) edge_count <= edge_count + 16'd1;
  end

  // free-running PWM counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

  // gates are live only in RUN; reset forces them off asynchronously via state
  always_comb begin
    phase_hi = 3'b000;
    phase_lo = 3'b000;
    if (state == RUN) begin
      phase_hi = drive_hi & {3{pwm_cnt < duty}};
      phase_lo = drive_lo;
    end
  end

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// Directed bench for bldc_commutation_ctrl (default parameters, stall build off).
module tb_bldc_commutation_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] hall;
  logic       enable, dir;
  logic [8:0] duty;
  logic [2:0] phase_hi, phase_lo, hall_state;
  logic       fault;
  logic [1:0] fault_code;
  logic [15:0] edge_count;

  int n_cmp = 0;
  int n_err = 0;
  int ovl   = 0;
  int zc, hc;

  bldc_commutation_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hall(hall), .enable(enable), .dir(dir), .duty(duty),
    .phase_hi(phase_hi), .phase_lo(phase_lo), .fault(fault), .fault_code(fault_code),
    .hall_state(hall_state), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock, sample 1ns after the edge, track hi/lo safety violations
  task automatic tick();
    @(posedge clk);
    #1;
    if ((phase_hi & phase_lo) != 3'b000) ovl++;
    if ($countones(phase_hi) > 1 || $countones(phase_lo) > 1) ovl++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // n clocks, returning how many had all low-side gates off
  task automatic count_zero(input int n, output int z);
    z = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (phase_lo == 3'b000) z++;
    end
  endtask

  logic [2:0] seq    [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
  logic [2:0] lo_exp [6] = '{3'b001, 3'b001, 3'b100, 3'b100, 3'b010, 3'b010};

  initial begin
    rst_n = 1'b0; hall = 3'b000; enable = 1'b0; dir = 1'b0; duty = 9'd256;
    ticks(3);
    chk("rst_hi", phase_hi, 3'b000);
    chk("rst_lo", phase_lo, 3'b000);
    chk("rst_fault", {fault, fault_code}, 3'b000);
    chk("rst_hall", hall_state, 3'b000);
    chk("rst_edges", edge_count, 16'd0);

    // start-up: accept after 2+4 clocks, then 8 dead clocks
    rst_n = 1'b1; enable = 1'b1; hall = 3'b101;
    ticks(5);
    chk("acc_t5", hall_state, 3'b000);
    tick();
    chk("acc_t6", hall_state, 3'b101);
    ticks(7);
    chk("dead_t13", phase_lo, 3'b000);
    tick();
    chk("run_t14_lo", phase_lo, 3'b010);
    hc = 0; zc = 0;
    for (int i = 0; i < 512; i++) begin
      tick();
      if (phase_hi == 3'b100) hc++;
      else if (phase_hi != 3'b000) zc++;
      if (phase_lo != 3'b010) zc++;
    end
    chk("pwm256_on", hc, 256);
    chk("pwm256_bad", zc, 0);

    // forward rotation, 8 dead clocks per step
    for (int s = 0; s < 6; s++) begin
      hall = seq[s];
      count_zero(30, zc);
      chk($sformatf("fwd%0d_dead", s), zc, 8);
      chk($sformatf("fwd%0d_lo", s), phase_lo, lo_exp[s]);
    end
    chk("fwd_edges", edge_count, 16'd6);

    // 2-clock glitch must be rejected
    hall = 3'b100; ticks(2); hall = 3'b101;
    count_zero(20, zc);
    chk("glitch_dead", zc, 0);
    chk("glitch_edges", edge_count, 16'd6);
    chk("glitch_hall", hall_state, 3'b101);

    // reverse direction
    dir = 1'b1;
    count_zero(20, zc);
    chk("dir_dead", zc, 8);
    chk("rev101_lo", phase_lo, 3'b100);
    hall = 3'b100; count_zero(30, zc);
    chk("rev100_lo", phase_lo, 3'b100);
    hall = 3'b110; count_zero(30, zc);
    chk("rev110_lo", phase_lo, 3'b010);
    duty = 9'd511; hc = 0;
    for (int i = 0; i < 512; i++) begin
      tick();
      if (phase_hi == 3'b001) hc++;
    end
    chk("pwm_max_on", hc, 511);

    // back to forward with duty 0
    dir = 1'b0; duty = 9'd0;
    count_zero(20, zc);
    chk("dir2_dead", zc, 8);
    chk("fwd110_lo", phase_lo, 3'b001);
    hc = 0;
    for (int i = 0; i < 512; i++) begin
      tick();
      if (phase_hi != 3'b000) hc++;
    end
    chk("pwm0_on", hc, 0);
    chk("edges8", edge_count, 16'd8);

    // enable falls on the same clock the edge is accepted
    duty = 9'd256; hall = 3'b010;
    ticks(5); enable = 1'b0; tick();
    chk("simul_lo", phase_lo, 3'b000);
    chk("simul_edges", edge_count, 16'd9);
    chk("simul_hall", hall_state, 3'b010);
    count_zero(20, zc);
    chk("simul_idle", zc, 20);

    // invalid hall 111
    enable = 1'b1;
    ticks(20);
    chk("re_run_lo", phase_lo, 3'b100);
    hall = 3'b111;
    ticks(5);
    chk("inv_t5_fault", fault, 1'b0);
    tick();
    chk("inv_fault", {fault, fault_code}, 3'b101);
    chk("inv_gates", {phase_hi, phase_lo}, 6'b0);
    enable = 1'b0; tick();
    chk("inv_clear", {fault, fault_code}, 3'b000);

    // illegal jump 101 -> 010, code holds through a later invalid hall
    hall = 3'b101; ticks(8);
    chk("jump_pre_hall", hall_state, 3'b101);
    chk("jump_pre_edges", edge_count, 16'd9);
    enable = 1'b1; tick();
    hall = 3'b010; ticks(6);
    chk("jump_fault", {fault, fault_code}, 3'b110);
    hall = 3'b111; ticks(8);
    chk("jump_hold", {fault, fault_code}, 3'b110);
    chk("jump_gates", {phase_hi, phase_lo}, 6'b0);
    enable = 1'b0; tick();
    chk("jump_clear", {fault, fault_code}, 3'b000);

    // asynchronous reset mid-run
    enable = 1'b1; hall = 3'b101;
    ticks(20);
    chk("pre_rst_lo", phase_lo, 3'b010);
    rst_n = 1'b0; #1;
    chk("async_rst_gates", {phase_hi, phase_lo}, 6'b0);
    chk("async_rst_edges", edge_count, 16'd0);

    chk("no_overlap", ovl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
